// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: handshake bus for mux_sel_pipe.
// Upstream (din/sel/in_valid/in_ready), downstream (dout/out_sel/out_valid/out_ready),
// and the sticky select-error flag with its clear.
interface mux_sel_pipe_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [SEL_W-1:0]          sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;
  logic                      err_clr;

  modport master (
    output din, sel, in_valid, out_ready, err_clr,
    input  in_ready, dout, out_sel, out_valid, sel_err
  );

  modport slave (
    input  din, sel, in_valid, out_ready, err_clr,
    output in_ready, dout, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered channel mux feeding a 2-entry FIFO.
// The selected channel and its select value are captured on an input transfer;
// the oldest entry is presented on dout/out_sel from registers.
// Optional feature: define MUX_SEL_PIPE_SELCHK_EN to enable the sticky
// out-of-range select flag sel_err (cleared by err_clr, set wins).
module mux_sel_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input logic           clk,
  input logic           rst_n,
  mux_sel_pipe_if.slave bus
);

  logic [WIDTH-1:0] mem_d [2];
  logic [SEL_W-1:0] mem_s [2];
  logic             wptr, rptr;
  logic [1:0]       count;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] dout_q;
  logic [SEL_W-1:0] out_sel_q;

  logic             push, pop;
  logic [WIDTH-1:0] cap_data;
  logic             sel_hit;
  logic [1:0]       count_n;
  logic             wptr_n, rptr_n;
  logic [WIDTH-1:0] head_d_n;
  logic [SEL_W-1:0] head_s_n;

  assign push = bus.in_valid && in_ready_q;
  assign pop  = out_valid_q && bus.out_ready;

  // Channel selection; an unmatched select falls back to channel 0.
  always_comb begin
    cap_data = bus.din[WIDTH-1:0];
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        cap_data = bus.din[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  // Occupancy/pointer update and next head entry.
  // The head comes from the incoming capture when the slot being written is the
  // slot the read pointer will point at (empty push, or push+pop with one entry).
  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
    wptr_n   = wptr ^ push;
    rptr_n   = rptr ^ pop;
    head_d_n = dout_q;
    head_s_n = out_sel_q;
    if (count_n != 2'd0) begin
      if (push && (wptr == rptr_n)) begin
        head_d_n = cap_data;
        head_s_n = bus.sel;
      end else begin
        head_d_n = mem_d[rptr_n];
        head_s_n = mem_s[rptr_n];
      end
    end
  end

  // FIFO storage write on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_d[0] <= '0;
      mem_d[1] <= '0;
      mem_s[0] <= '0;
      mem_s[1] <= '0;
    end else if (push) begin
      mem_d[wptr] <= cap_data;
      mem_s[wptr] <= bus.sel;
    end
  end

  // Control state and registered head/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sel_q   <= '0;
    end else begin
      count       <= count_n;
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      in_ready_q  <= (count_n != 2'd2);
      out_valid_q <= (count_n != 2'd0);
      dout_q      <= head_d_n;
      out_sel_q   <= head_s_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_sel   = out_sel_q;

`ifdef MUX_SEL_PIPE_SELCHK_EN
  logic sel_err_q;

  // Sticky out-of-range flag; a setting transfer beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (push && !sel_hit) begin
      sel_err_q <= 1'b1;
    end else if (bus.err_clr) begin
      sel_err_q <= 1'b0;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  logic [1:0] unused_chk;
  assign unused_chk  = {bus.err_clr, sel_hit};
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: doc/mux_sel_pipe.md
MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width per channel, 1..64.
REQ-002 Parameter CHANNELS, default 4: number of input channels, 2..16.
REQ-003 Parameter SEL_W, default 2: select width; SHALL be at least ceil(log2(CHANNELS)).
REQ-004 Port clk  in  1: single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n  in  1: asynchronous, active-low reset.
REQ-006 Port din  in  CHANNELS*WIDTH: flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port sel  in  SEL_W: channel select, sampled with in_valid.
REQ-008 Port in_valid  in  1: upstream transfer request.
REQ-009 Port in_ready  out  1: block can accept a transfer.
REQ-010 Port dout  out  WIDTH: selected data at the buffer head.
REQ-011 Port out_sel  out  SEL_W: select value that produced dout.
REQ-012 Port out_valid  out  1: dout and out_sel are valid.
REQ-013 Port out_ready  in  1: downstream accepts the head entry.
REQ-014 Port sel_err  out  1: sticky out-of-range select flag (see Configuration).
REQ-015 Port err_clr  in  1: synchronous clear for sel_err.

Function
REQ-016 Input transfer SHALL occur on a clock edge where in_valid && in_ready; output transfer SHALL occur where out_valid && out_ready.
REQ-017 On an input transfer, the block SHALL capture din channel sel together with sel itself into a 2-entry FIFO.
REQ-018 Latency: data accepted at edge N SHALL appear on dout with out_valid=1 after edge N when the FIFO was empty, i.e. one cycle; the block SHALL have no combinational path from din to dout.
REQ-019 in_ready SHALL be (count < 2), registered state only; it SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL be (count != 0); dout and out_sel SHALL show the oldest entry.
REQ-021 Simultaneous input and output transfer SHALL leave count unchanged; ordering SHALL be strictly FIFO; sustained throughput SHALL be one transfer per cycle.
REQ-022 Full (count=2): in_valid SHALL be ignored and no entry overwritten. Empty: dout SHALL hold its last value; out_ready SHALL be ignored.
REQ-023 FIFO read/write pointers are 1 bit each and SHALL wrap 1->0.
REQ-024 dout, out_sel and out_valid SHALL be stable while out_valid && !out_ready.
REQ-025 An out-of-range select (sel >= CHANNELS) SHALL capture channel 0 data and the raw sel value.

Reset
REQ-026 While rst_n=0, asynchronously: count=0, both pointers=0, out_valid=0, in_ready=0, dout=0, out_sel=0, sel_err=0.
REQ-027 in_ready SHALL rise on the first clock edge after rst_n deasserts; reset mid-transfer SHALL discard all buffered entries.

Configuration
REQ-028 Macro MUX_SEL_PIPE_SELCHK_EN defined: sel_err SHALL set on an input transfer with sel >= CHANNELS; it SHALL clear on err_clr=1, and set wins if both occur in the same cycle.
REQ-029 Macro MUX_SEL_PIPE_SELCHK_EN undefined: sel_err SHALL be constant 0, err_clr SHALL be ignored, and no check logic SHALL be generated; REQ-025 data behaviour still applies.

Verification
REQ-030 Reset, then sel=2, din ch2=32'hDEADBEEF, one in_valid pulse with out_ready=1 -> next cycle out_valid=1, dout=DEADBEEF, out_sel=2.
REQ-031 out_ready=0, push ch1=11, ch3=33, then attempt ch0=55 -> in_ready=0 after two pushes, third push dropped; on out_ready=1, dout sequence is 11 then 33.
REQ-032 Continuous in_valid and out_ready, sel cycling 0..3 for 16 cycles -> one output per cycle, in order, no bubbles after the first.
REQ-033 CHANNELS=3, macro defined, push sel=3 -> dout=ch0 data, out_sel=3, sel_err=1 until err_clr; with set and clear in the same cycle, sel_err stays 1. Macro undefined -> sel_err stays 0.
REQ-034 Two entries buffered, rst_n pulsed low mid-cycle -> out_valid=0 and dout=0 immediately; in_ready=1 one edge after release.
